spi_master_duplex: RTL and testbench

SPI_MASTER_DUPLEX -- requirements
Module: spi_master_duplex

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_master_duplex_if.sv | 29 ++
 rtl/spi_tick_gen.sv | 24 ++
 rtl/spi_master_duplex.sv | 137 +++++++++++++
 tb/tb_spi_master_duplex.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared FSM encoding and mode-field packing for the duplex SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    localparam int unsigned MODE_BITS = 3;

    typedef struct packed {
        logic lsb_first;
        logic cpha;
        logic cpol;
    } spi_mode_t;

    function automatic spi_mode_t pack_mode(input logic lsb_first, input logic cpha, input logic cpol);
        spi_mode_t m;
        m.lsb_first = lsb_first;
        m.cpha      = cpha;
        m.cpol      = cpol;
        return m;
    endfunction

endpackage

// File: rtl/spi_master_duplex_if.sv
// Host request/response signals plus the four SPI wires of one master port.
interface spi_master_duplex_if #(
    parameter int unsigned BITS     = 8,
    parameter int unsigned DIV_BITS = 4
);
    logic                start;
    logic [DIV_BITS-1:0] div;
    logic                cpol;
    logic                cpha;
    logic                lsb_first;
    logic [BITS-1:0]     in_buf;
    logic [BITS-1:0]     out_buf;
    logic                busy;
    logic                done;
    logic                sck;
    logic                cs;
    logic                mosi;
    logic                miso;

    modport master (
        input  start, div, cpol, cpha, lsb_first, in_buf, miso,
        output out_buf, busy, done, sck, cs, mosi
    );

    modport slave (
        output start, div, cpol, cpha, lsb_first, in_buf, miso,
        input  out_buf, busy, done, sck, cs, mosi
    );
endinterface

// File: rtl/spi_tick_gen.sv
// Half-period strobe: down-counter reloaded from div, pulses on the last clk of each half-period.
module spi_tick_gen #(
    parameter int unsigned DIV_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [DIV_BITS-1:0] div,
    output logic                tick_c
);
    logic [DIV_BITS-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load || cnt == '0) begin
            cnt <= div;
        end else begin
            cnt <= cnt - DIV_BITS'(1);
        end
    end

    assign tick_c = (cnt == '0);
endmodule

// File: rtl/spi_master_duplex.sv
// Full-duplex SPI master: one frame of BITS bits per start, all four CPOL/CPHA modes, either bit order.
module spi_master_duplex
    import spi_pkg::*;
#(
    parameter int unsigned BITS     = 8,
    parameter int unsigned DIV_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    spi_master_duplex_if.master bus
);
    localparam int unsigned CNT_W    = $clog2(2 * BITS + 1);
    localparam int unsigned LAST_TOG = 2 * BITS;

    spi_state_t          state, state_nxt;
    spi_mode_t           mode_q;
    logic [DIV_BITS-1:0] div_q;
    logic [BITS-1:0]     tx_sr, rx_sr, out_q;
    logic [CNT_W-1:0]    tog_cnt;
    logic                sck_q, cs_q, mosi_q, busy_q, done_q;
    logic                tick_c, start_c, toggle_c, last_c, sample_c, advance_c;

    function automatic logic head_bit(input logic [BITS-1:0] w, input logic lsb);
        return lsb ? w[0] : w[BITS-1];
    endfunction

    function automatic logic [BITS-1:0] shift_out(input logic [BITS-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign start_c = (state == IDLE) && bus.start;

    spi_tick_gen #(.DIV_BITS(DIV_BITS)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .load   (start_c),
        .div    (start_c ? bus.div : div_q),
        .tick_c (tick_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus per-toggle strobes; toggle k = tog_cnt+1, odd k when tog_cnt[0]==0.
    always_comb begin
        state_nxt = state;
        toggle_c  = 1'b0;
        last_c    = 1'b0;
        case (state)
            IDLE:  if (start_c) state_nxt = SETUP;
            SETUP: if (tick_c) state_nxt = SHIFT;
            SHIFT: begin
                if (tick_c) begin
                    toggle_c = 1'b1;
                    if (tog_cnt == CNT_W'(LAST_TOG - 1)) begin
                        last_c    = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD:  if (tick_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        sample_c  = toggle_c && (tog_cnt[0] == mode_q.cpha);
        advance_c = toggle_c && (tog_cnt[0] != mode_q.cpha) && !last_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= '0;
            div_q   <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            out_q   <= '0;
            tog_cnt <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_c) begin
                mode_q  <= pack_mode(bus.lsb_first, bus.cpha, bus.cpol);
                div_q   <= bus.div;
                rx_sr   <= '0;
                tog_cnt <= '0;
                sck_q   <= bus.cpol;
                cs_q    <= 1'b0;
                busy_q  <= 1'b1;
                // cpha=0 presents the first bit before the leading edge
                if (bus.cpha) begin
                    mosi_q <= 1'b0;
                    tx_sr  <= bus.in_buf;
                end else begin
                    mosi_q <= head_bit(bus.in_buf, bus.lsb_first);
                    tx_sr  <= shift_out(bus.in_buf, bus.lsb_first);
                end
            end else if (state == IDLE) begin
                sck_q  <= bus.cpol;
                mosi_q <= 1'b0;
            end
            if (toggle_c) begin
                sck_q   <= ~sck_q;
                tog_cnt <= tog_cnt + CNT_W'(1);
            end
            if (sample_c) begin
                rx_sr <= mode_q.lsb_first ? {bus.miso, rx_sr[BITS-1:1]}
                                          : {rx_sr[BITS-2:0], bus.miso};
            end
            if (advance_c) begin
                mosi_q <= head_bit(tx_sr, mode_q.lsb_first);
                tx_sr  <= shift_out(tx_sr, mode_q.lsb_first);
            end
            if (state == HOLD && tick_c) begin
                sck_q  <= mode_q.cpol;
                cs_q   <= 1'b1;
                mosi_q <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                out_q  <= rx_sr;
            end
        end
    end

    assign bus.sck     = sck_q;
    assign bus.cs      = cs_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.out_buf = out_q;
endmodule

// File: tb/tb_spi_master_duplex.sv
// Randomised bench for spi_master_duplex against a bit-level slave model and frame timing formulae.
module tb_spi_master_duplex;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    spi_master_duplex_if #(.BITS(8),  .DIV_BITS(4)) if8 ();
    spi_master_duplex_if #(.BITS(16), .DIV_BITS(4)) if16 ();

    spi_master_duplex #(.BITS(8),  .DIV_BITS(4)) dut8  (.clk(clk), .reset(reset), .bus(if8));
    spi_master_duplex #(.BITS(16), .DIV_BITS(4)) dut16 (.clk(clk), .reset(reset), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic sbit(input logic [7:0] w, input int i, input logic lsb);
        return lsb ? w[i] : w[7-i];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one 8-bit frame as an ideal slave; n counts samples after the start edge (n=1 first).
    task automatic run_frame(input logic [3:0] dv, input logic pol, input logic pha, input logic lsb,
                             input logic [7:0] tx, input logic [7:0] slv, input bit hold_start,
                             output int busy_cycles, output int done_n, output int toggles,
                             output logic [7:0] mosi_word, output logic [7:0] rx,
                             output logic cs_first, output logic sck_first, output bit tog_ok);
        int   h;
        int   n;
        int   k;
        int   nb;
        logic prev;
        h = int'(dv) + 1;
        if8.div = dv; if8.cpol = pol; if8.cpha = pha; if8.lsb_first = lsb;
        if8.in_buf = tx; if8.start = 1'b1;
        step();
        n = 1; k = 0; nb = 0;
        busy_cycles = 0; done_n = 0; mosi_word = '0; rx = 'x; tog_ok = 1'b1;
        cs_first = if8.cs; sck_first = if8.sck; prev = if8.sck;
        if (!pha) if8.miso = sbit(slv, 0, lsb);
        while (1) begin
            if (if8.busy === 1'b1) busy_cycles++;
            if (if8.sck !== prev) begin
                k++;
                prev = if8.sck;
                if (n != (k + 1) * h + 1) tog_ok = 1'b0;
                if ((k % 2 == 1) != pha) begin
                    if (nb < 8) mosi_word[lsb ? nb : 7 - nb] = if8.mosi;
                    nb++;
                end
                if (!pha && k % 2 == 0 && k / 2 < 8) if8.miso = sbit(slv, k / 2, lsb);
                if (pha && k % 2 == 1) if8.miso = sbit(slv, (k - 1) / 2, lsb);
            end
            if (if8.done === 1'b1) begin
                done_n = n;
                rx = if8.out_buf;
                break;
            end
            if (n >= 300) break;
            if8.start = hold_start && (n < 16);
            if8.div = 4'($urandom); if8.cpol = 1'($urandom); if8.cpha = 1'($urandom);
            if8.lsb_first = 1'($urandom); if8.in_buf = 8'($urandom);
            step();
            n++;
        end
        toggles = k;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if8.start = 1'b1;
        step(); step();
        checks++; if (if8.sck !== 1'b0)  begin errors++; $display("FAIL reset_sck got %b exp 0", if8.sck); end
        checks++; if (if8.cs !== 1'b1)   begin errors++; $display("FAIL reset_cs got %b exp 1", if8.cs); end
        checks++; if (if8.mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", if8.mosi); end
        checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", if8.busy); end
        checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", if8.done); end
        checks++; if (if8.out_buf !== 8'h00) begin errors++; $display("FAIL reset_out_buf got %h exp 00", if8.out_buf); end
        checks++; if (if16.out_buf !== 16'h0000) begin errors++; $display("FAIL reset_out_buf16 got %h exp 0000", if16.out_buf); end
        if8.start = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_mode0();
        int bc, dn, tg; logic [7:0] mw, rx; logic csf, sckf; bit tok;
        run_frame(4'd0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, bc, dn, tg, mw, rx, csf, sckf, tok);
        checks++; if (bc != 18) begin errors++; $display("FAIL m0_busy_cycles got %0d exp 18", bc); end
        checks++; if (dn != 19) begin errors++; $display("FAIL m0_done_time got %0d exp 19", dn); end
        checks++; if (rx !== 8'h3C) begin errors++; $display("FAIL m0_out_buf got %h exp 3c", rx); end
        checks++; if (mw !== 8'hA5) begin errors++; $display("FAIL m0_mosi_bits got %h exp a5", mw); end
        checks++; if (tg != 16 || !tok) begin errors++; $display("FAIL m0_sck_toggles got %0d ok=%0d exp 16 ok=1", tg, tok); end
        checks++; if (csf !== 1'b0) begin errors++; $display("FAIL m0_cs_low got %b exp 0", csf); end
        checks++; if (if8.cs !== 1'b1 || if8.busy !== 1'b0 || if8.mosi !== 1'b0)
            begin errors++; $display("FAIL m0_done_cycle got cs=%b busy=%b mosi=%b exp 1 0 0", if8.cs, if8.busy, if8.mosi); end
        step();
        checks++; if (if8.done !== 1'b0 || if8.out_buf !== 8'h3C)
            begin errors++; $display("FAIL m0_after_done got done=%b out=%h exp 0 3c", if8.done, if8.out_buf); end
    endtask

    task automatic test_mode3();
        int bc, dn, tg; logic [7:0] mw, rx, slv; logic csf, sckf; bit tok;
        if8.cpol = 1'b1;
        step(); step();
        checks++; if (if8.sck !== 1'b1) begin errors++; $display("FAIL m3_idle_sck got %b exp 1", if8.sck); end
        checks++; if (if8.mosi !== 1'b0) begin errors++; $display("FAIL m3_idle_mosi got %b exp 0", if8.mosi); end
        slv = 8'($urandom);
        run_frame(4'd3, 1'b1, 1'b1, 1'b1, 8'h01, slv, 1'b0, bc, dn, tg, mw, rx, csf, sckf, tok);
        checks++; if (dn != 73) begin errors++; $display("FAIL m3_done_time got %0d exp 73", dn); end
        checks++; if (bc != 72) begin errors++; $display("FAIL m3_busy_cycles got %0d exp 72", bc); end
        checks++; if (tg != 16 || !tok || sckf !== 1'b1)
            begin errors++; $display("FAIL m3_sck_timing got tog=%0d ok=%0d start=%b exp 16 1 1", tg, tok, sckf); end
        checks++; if (mw !== 8'h01) begin errors++; $display("FAIL m3_mosi_bits got %h exp 01", mw); end
        checks++; if (rx !== slv) begin errors++; $display("FAIL m3_out_buf got %h exp %h", rx, slv); end
    endtask

    task automatic test_random();
        int bc, dn, tg, h; logic [7:0] mw, rx, tx, slv; logic csf, sckf; bit tok;
        logic [3:0] dv; logic pol, pha, lsb;
        for (int it = 0; it < 24; it++) begin
            dv = 4'($urandom_range(0, 3)); pol = 1'($urandom); pha = 1'($urandom); lsb = 1'($urandom);
            tx = 8'($urandom); slv = 8'($urandom); h = int'(dv) + 1;
            run_frame(dv, pol, pha, lsb, tx, slv, 1'b0, bc, dn, tg, mw, rx, csf, sckf, tok);
            checks++; if (rx !== slv || mw !== tx)
                begin errors++; $display("FAIL rnd%0d_data got rx=%h mosi=%h exp %h %h", it, rx, mw, slv, tx); end
            checks++; if (bc != 18 * h || dn != 18 * h + 1 || tg != 16 || !tok || sckf !== pol)
                begin errors++; $display("FAIL rnd%0d_timing got busy=%0d done=%0d tog=%0d ok=%0d sck=%b exp %0d %0d 16 1 %b",
                                         it, bc, dn, tg, tok, sckf, 18 * h, 18 * h + 1, pol); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int bc, dn, tg, frames; logic [7:0] mw, rx, s1, s2, t2; logic csf, sckf, prev_busy; bit tok;
        s1 = 8'($urandom); s2 = 8'($urandom); t2 = 8'($urandom);
        run_frame(4'd0, 1'b0, 1'b0, 1'b0, 8'h5A, s1, 1'b0, bc, dn, tg, mw, rx, csf, sckf, tok);
        checks++; if (dn != 19 || rx !== s1) begin errors++; $display("FAIL b2b_first got done=%0d out=%h exp 19 %h", dn, rx, s1); end
        checks++; if (if8.cs !== 1'b1) begin errors++; $display("FAIL b2b_gap_cs got %b exp 1", if8.cs); end
        run_frame(4'd1, 1'b0, 1'b1, 1'b1, t2, s2, 1'b1, bc, dn, tg, mw, rx, csf, sckf, tok);
        checks++; if (csf !== 1'b0) begin errors++; $display("FAIL b2b_gap_len got cs=%b exp 0", csf); end
        checks++; if (dn != 37 || rx !== s2 || mw !== t2)
            begin errors++; $display("FAIL b2b_second got done=%0d out=%h mosi=%h exp 37 %h %h", dn, rx, mw, s2, t2); end
        frames = 0; prev_busy = if8.busy;
        for (int i = 0; i < 40; i++) begin
            step();
            if (if8.busy === 1'b1 && prev_busy !== 1'b1) frames++;
            prev_busy = if8.busy;
        end
        checks++; if (frames != 0) begin errors++; $display("FAIL b2b_extra_frames got %0d exp 0", frames); end
    endtask

    task automatic test_reset_midframe();
        int dones;
        reset = 1'b1; step(); reset = 1'b0; step();
        if8.div = 4'd0; if8.cpol = 1'b1; if8.cpha = 1'b0; if8.lsb_first = 1'b0;
        if8.in_buf = 8'hC3; if8.miso = 1'b1; if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        for (int i = 1; i < 10; i++) step();
        checks++; if (if8.busy !== 1'b1) begin errors++; $display("FAIL abort_in_frame got busy=%b exp 1", if8.busy); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (if8.cs !== 1'b1 || if8.sck !== 1'b0 || if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.mosi !== 1'b0)
            begin errors++; $display("FAIL abort_outputs got cs=%b sck=%b busy=%b done=%b mosi=%b exp 1 0 0 0 0",
                                     if8.cs, if8.sck, if8.busy, if8.done, if8.mosi); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (if8.done === 1'b1) dones++;
        end
        checks++; if (dones != 0 || if8.out_buf !== 8'h00)
            begin errors++; $display("FAIL abort_no_done got dones=%0d out=%h exp 0 00", dones, if8.out_buf); end
    endtask

    task automatic test_wide();
        int n, bc, dn;
        if16.div = 4'd1; if16.cpol = 1'($urandom); if16.cpha = 1'b1; if16.lsb_first = 1'($urandom);
        if16.in_buf = 16'($urandom); if16.miso = 1'b1; if16.start = 1'b1;
        step();
        if16.start = 1'b0;
        n = 1; bc = 0; dn = 0;
        while (n < 200) begin
            if (if16.busy === 1'b1) bc++;
            if (if16.done === 1'b1) begin dn = n; break; end
            step();
            n++;
        end
        checks++; if (bc != 68 || dn != 69) begin errors++; $display("FAIL wide_timing got busy=%0d done=%0d exp 68 69", bc, dn); end
        checks++; if (if16.out_buf !== 16'hFFFF) begin errors++; $display("FAIL wide_out_buf got %h exp ffff", if16.out_buf); end
    endtask

    initial begin
        reset = 1'b1;
        if8.start = 1'b0; if8.div = '0; if8.cpol = 1'b0; if8.cpha = 1'b0;
        if8.lsb_first = 1'b0; if8.in_buf = '0; if8.miso = 1'b0;
        if16.start = 1'b0; if16.div = '0; if16.cpol = 1'b0; if16.cpha = 1'b0;
        if16.lsb_first = 1'b0; if16.in_buf = '0; if16.miso = 1'b0;
        #1;
        test_reset();
        test_mode0();
        test_mode3();
        test_random();
        test_back_to_back();
        test_reset_midframe();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
